mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline, sitting in the E stage beside the ALU. It sequences multi-cycle `mult`/`multu`/`div`/`divu` and single-cycle `mthi`/`mtlo`, and owns HI/LO. It also generates the busy-based stall request that the hazard controller ORs into its stall term so that no HI/LO-touching instruction leaves D while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all state immediately.
- `MDOp_E` input, 3 bits: E-stage operation code, from the shared `MD_*` constants.
- `A_E` input, 32 bits: forwarded rs value (ALU A path after forwarding mux).
- `B_E` input, 32 bits: forwarded rt value.
- `MDInstr_D` input, 1 bit: the D-stage instruction is mult, multu, div, divu, mfhi, mflo, mthi or mtlo.
- `HI` output, 32 bits: architectural HI. Reset value 0.
- `LO` output, 32 bits: architectural LO. Reset value 0.
- `Busy` output, 1 bit: operation in flight. Reset value 0.
- `Stall_MD` output, 1 bit: stall request to the hazard controller. Reset value 0.

## Operation
- Op codes: `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4, `MD_MTHI`=5, `MD_MTLO`=6. Codes 7 and above are treated as `MD_NONE`.
- FSM has two states:
  - IDLE:
    - An edge with op 1–4 latches the result into the pending registers `PHI`/`PLO`, loads the counter with N−1 (N = `MULT_CYCLES` or `DIV_CYCLES`) and moves to BUSY.
    - An edge with op 5 or 6 writes `A_E` into HI or LO and stays in IDLE.
  - BUSY:
    - Each edge decrements the counter.
    - On the edge where the counter is 0, `PHI`/`PLO` are committed to HI/LO and the FSM returns to IDLE.
    - Any `MDOp_E` seen while in BUSY is ignored. Hazard stalling makes this unreachable in practice; it is still required behaviour.
- `Busy` = (state == BUSY).
- `Stall_MD` is combinational: `MDInstr_D` && (`Busy` || `MDOp_E` ∈ {1..4}).
- Multiply arithmetic:
  - `mult`: 64-bit signed product. HI gets bits [63:32], LO gets bits [31:0].
  - `multu`: the same, unsigned.
- Divide arithmetic:
  - `div`: signed. Quotient goes to LO and truncates toward zero. Remainder goes to HI and takes the sign of the dividend.
  - `divu`: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - B_E == 0: PHI/PLO are loaded with the current HI/LO, so the architectural values are unchanged. The full `DIV_CYCLES` busy period still runs.
- HI/LO never show partial or pending values. Reads (mfhi/mflo) only proceed once `Stall_MD` is low, so they always see committed values.

## Timing
- Op 1–4 is sampled at edge t:
  - `Busy` = 1 from after edge t until edge t+N.
  - HI/LO update and `Busy` falls at edge t+N.
- A dependent mfhi/mflo held in D is stalled for N+1 cycles: the issue cycle plus N busy cycles.
- `mthi`/`mtlo`: written at the edge they are sampled, with no busy period. The next cycle already sees the new value.
- Back-to-back ops: a new op is accepted at the first edge after `Busy` falls.
- Reset asserted mid-operation: state returns to IDLE, and counter, `PHI`/`PLO`, HI and LO all clear to 0 asynchronously. The pending result is discarded.
- Counter width is $clog2(max(`MULT_CYCLES`,`DIV_CYCLES`)). It must not wrap; N ≥ 1 is required.

## Structure
- The `MD_*` op constants go in the shared `define.v`, next to the existing forwarding/RFWD codes, so the decoder, the hazard controller and this block agree on the encoding.
- Control and arithmetic stay in a single module with no sub-module. The combinational product/quotient logic is a local function/always block feeding `PHI`/`PLO`.
- The hazard controller ORs `Stall_MD` into its existing stall term, driving `En_PC`, `En_RegFD` and `Clr_RegDE`.

## Test plan
- `mult` with A=0xFFFFFFFF, B=2 → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. `multu` with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- `div` with A=0xFFFFFFF9 (−7), B=2 → at edge t+10 LO=0xFFFFFFFD, HI=0xFFFFFFFF. `divu` with A=7, B=2 → LO=3, HI=1. 0x80000000/0xFFFFFFFF signed → LO=0x80000000, HI=0.
- `mult` issued with `MDInstr_D`=1 throughout → `Stall_MD` high for exactly 6 cycles and `Busy` high for exactly 5. `MDInstr_D`=0 → `Stall_MD` stays 0.
- Divide by zero with HI=0x11, LO=0x22 beforehand → `Busy` lasts 10 cycles, then HI=0x11, LO=0x22.
- `reset` pulsed 4 cycles into a `div` → `Busy`, HI and LO all read 0 before the next edge, and the FSM accepts a new `mult` on the following edge.
- `mthi` A=0xABCD in IDLE → HI=0xABCD next cycle, `Busy` stays 0. `mtlo` presented while `Busy`=1 → LO unchanged.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: MD_* op codes,
// FSM states and small classification helpers.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Multi-cycle ops; code 7 falls outside every class and acts as MD_NONE.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-facing bundle of the multiply/divide unit: E-stage op and operands,
// D-stage hazard hint, and HI/LO/Busy/Stall_MD back to the pipeline.
interface mult_div_unit_if;
  logic [2:0]  MDOp_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        MDInstr_D;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Stall_MD;

  modport master (
    output MDOp_E, A_E, B_E, MDInstr_D,
    input  HI, LO, Busy, Stall_MD
  );

  modport slave (
    input  MDOp_E, A_E, B_E, MDInstr_D,
    output HI, LO, Busy, Stall_MD
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning HI/LO: results are computed at issue, held in
// PHI/PLO for the busy period and committed to HI/LO when the counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      phi, plo;
  logic [31:0]      hi_q, lo_q;

  // Returns {hi, lo}. Divide by zero hands back the current HI/LO so the
  // later commit leaves the architectural values untouched.
  function automatic logic [63:0] md_compute(input logic [2:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] hi,
                                             input logic [31:0] lo);
    logic [63:0] result;
    logic [63:0] a_ext, b_ext;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
    result = {hi, lo};
    a_ext  = {32'd0, a};
    b_ext  = {32'd0, b};
    a_neg  = (op == MD_DIV) && a[31];
    b_neg  = (op == MD_DIV) && b[31];
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    q_mag  = '0;
    r_mag  = '0;
    q      = '0;
    r      = '0;
    case (op)
      MD_MULT: begin
        a_ext  = {{32{a[31]}}, a};
        b_ext  = {{32{b[31]}}, b};
        result = a_ext * b_ext;
      end
      MD_MULTU: result = a_ext * b_ext;
      MD_DIV, MD_DIVU: begin
        // Sign-magnitude division: 0x80000000 / -1 wraps back to 0x80000000.
        if (b != 32'd0) begin
          q_mag  = a_mag / b_mag;
          r_mag  = a_mag % b_mag;
          q      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
          r      = a_neg ? (32'd0 - r_mag) : r_mag;
          result = {r, q};
        end
      end
      default: result = {hi, lo};
    endcase
    return result;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      phi   <= '0;
      plo   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_long_op(md.MDOp_E)) begin
            {phi, plo} <= md_compute(md.MDOp_E, md.A_E, md.B_E, hi_q, lo_q);
            cnt        <= is_mult_op(md.MDOp_E) ? MULT_LOAD : DIV_LOAD;
            state      <= ST_BUSY;
          end else if (md.MDOp_E == MD_MTHI) begin
            hi_q <= md.A_E;
          end else if (md.MDOp_E == MD_MTLO) begin
            lo_q <= md.A_E;
          end
        end
        ST_BUSY: begin
          // Ops presented while busy are dropped; the hazard stall normally prevents them.
          if (cnt == '0) begin
            hi_q  <= phi;
            lo_q  <= plo;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.Busy     = (state == ST_BUSY);
  assign md.Stall_MD = md.MDInstr_D && ((state == ST_BUSY) || is_long_op(md.MDOp_E));

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table of mult/div results plus
// hand sequences for stall length, mthi/mtlo, ops while busy and mid-op reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic clk;
  logic reset;

  mult_div_unit_if md_bus ();

  mult_div_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [31:0] hi_m, lo_m;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        preset;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mdi);
    md_bus.MDOp_E    = op;
    md_bus.A_E       = a;
    md_bus.B_E       = b;
    md_bus.MDInstr_D = mdi;
  endtask

  // Inputs already driven (away from the edge); applies mthi/mtlo, ends at a negedge.
  task automatic mt_write(input string name, input logic [2:0] op, input logic [31:0] val);
    drive(op, val, 32'd0, 1'b1);
    #1;
    check({name, " stall"}, 64'(md_bus.Stall_MD), 64'd0);
    @(posedge clk);
    #1 drive(MD_NONE, 32'd0, 32'd0, 1'b1);
    if (op == MD_MTHI) hi_m = val;
    else               lo_m = val;
    @(negedge clk);
    check({name, " hi"}, 64'(md_bus.HI), 64'(hi_m));
    check({name, " lo"}, 64'(md_bus.LO), 64'(lo_m));
    check({name, " busy"}, 64'(md_bus.Busy), 64'd0);
  endtask

  // Long op already driven; walks issue + busy period, checks timing and
  // the scoreboarded result. Optionally presents mtlo mid-busy. Ends at a negedge.
  task automatic run_long(input string name, input int n, input logic mdi,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic inject);
    int busy_cyc  = 0;
    int stall_cyc = 0;
    logic [63:0] exp_res;
    sb_q.push_back({exp_hi, exp_lo});
    #1;
    if (md_bus.Stall_MD) stall_cyc++;
    check({name, " busy before issue"}, 64'(md_bus.Busy), 64'd0);
    @(posedge clk);
    #1 md_bus.MDOp_E = MD_NONE;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (md_bus.Stall_MD) stall_cyc++;
      if (!md_bus.Busy) break;
      busy_cyc++;
      if (busy_cyc == 1) begin
        check({name, " hi hidden"}, 64'(md_bus.HI), 64'(hi_m));
        check({name, " lo hidden"}, 64'(md_bus.LO), 64'(lo_m));
      end
      if (inject && busy_cyc == 2) begin
        md_bus.MDOp_E = MD_MTLO;
        md_bus.A_E    = 32'hDEAD_BEEF;
      end
      if (inject && busy_cyc == 3) begin
        md_bus.MDOp_E = MD_NONE;
        check({name, " mtlo ignored"}, 64'(md_bus.LO), 64'(lo_m));
      end
    end
    check({name, " busy cycles"}, 64'(busy_cyc), 64'(n));
    check({name, " stall cycles"}, 64'(stall_cyc), mdi ? 64'(n + 1) : 64'd0);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      exp_res = sb_q.pop_front();
      check({name, " hi"}, 64'(md_bus.HI), 64'(exp_res[63:32]));
      check({name, " lo"}, 64'(md_bus.LO), 64'(exp_res[31:0]));
      hi_m = exp_res[63:32];
      lo_m = exp_res[31:0];
    end
  endtask

  function automatic int cycles_for(input logic [2:0] op);
    return ((op == MD_MULT) || (op == MD_MULTU)) ? N_MULT : N_DIV;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"mult -1*2",     MD_MULT,  32'hFFFF_FFFF, 32'd2,          1'b0, 32'd0,  32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{"multu ff*2",    MD_MULTU, 32'hFFFF_FFFF, 32'd2,          1'b0, 32'd0,  32'd0,  32'h0000_0001, 32'hFFFF_FFFE});
    vecs.push_back('{"mult min*min",  MD_MULT,  32'h8000_0000, 32'h8000_0000,  1'b0, 32'd0,  32'd0,  32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"multu ff*ff",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'd0,  32'd0,  32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"div -7/2",      MD_DIV,   32'hFFFF_FFF9, 32'd2,          1'b0, 32'd0,  32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu 7/2",      MD_DIVU,  32'd7,         32'd2,          1'b0, 32'd0,  32'd0,  32'h0000_0001, 32'h0000_0003});
    vecs.push_back('{"div min/-1",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'd0,  32'd0,  32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"div 7/-2",      MD_DIV,   32'd7,         32'hFFFF_FFFE,  1'b0, 32'd0,  32'd0,  32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{"div -7/-2",     MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE,  1'b0, 32'd0,  32'd0,  32'hFFFF_FFFF, 32'h0000_0003});
    vecs.push_back('{"divu ff/10",    MD_DIVU,  32'hFFFF_FFFF, 32'd10,         1'b0, 32'd0,  32'd0,  32'h0000_0005, 32'h1999_9999});
    vecs.push_back('{"div by zero",   MD_DIV,   32'd1234,      32'd0,          1'b1, 32'h11, 32'h22, 32'h0000_0011, 32'h0000_0022});
    vecs.push_back('{"divu by zero",  MD_DIVU,  32'd5,         32'd0,          1'b0, 32'd0,  32'd0,  32'h0000_0011, 32'h0000_0022});

    hi_m  = '0;
    lo_m  = '0;
    reset = 1'b1;
    drive(MD_NONE, 32'd0, 32'd0, 1'b1);
    repeat (2) @(negedge clk);
    check("reset hi", 64'(md_bus.HI), 64'd0);
    check("reset lo", 64'(md_bus.LO), 64'd0);
    check("reset busy", 64'(md_bus.Busy), 64'd0);
    check("reset stall", 64'(md_bus.Stall_MD), 64'd0);
    reset = 1'b0;

    // Table: each op is driven at the negedge where Busy is first seen low,
    // so it is accepted on the first edge after the previous op completes.
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].preset) begin
        mt_write({vecs[i].name, " pre mthi"}, MD_MTHI, vecs[i].pre_hi);
        mt_write({vecs[i].name, " pre mtlo"}, MD_MTLO, vecs[i].pre_lo);
      end
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      run_long(vecs[i].name, cycles_for(vecs[i].op), 1'b1, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
    end

    // No MD instruction in D: never stall.
    drive(MD_MULTU, 32'd3, 32'd4, 1'b0);
    run_long("multu no stall", N_MULT, 1'b0, 32'd0, 32'd12, 1'b0);

    // mthi in IDLE takes effect for the next cycle with no busy period.
    mt_write("mthi abcd", MD_MTHI, 32'h0000_ABCD);

    // mtlo presented while busy must be ignored.
    drive(MD_DIVU, 32'd100, 32'd7, 1'b1);
    run_long("divu mtlo while busy", N_DIV, 1'b1, 32'd2, 32'd14, 1'b1);

    // Reset pulsed four cycles into a div clears everything before the next edge.
    drive(MD_DIVU, 32'd7, 32'd2, 1'b1);
    @(posedge clk);
    #1 drive(MD_NONE, 32'd0, 32'd0, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset busy", 64'(md_bus.Busy), 64'd0);
    check("mid reset hi", 64'(md_bus.HI), 64'd0);
    check("mid reset lo", 64'(md_bus.LO), 64'd0);
    check("mid reset stall", 64'(md_bus.Stall_MD), 64'd0);
    hi_m = '0;
    lo_m = '0;
    #1 reset = 1'b0;
    drive(MD_MULT, 32'd3, 32'hFFFF_FFFB, 1'b1);
    run_long("mult after reset", N_MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
